// File: rtl/dcache_responder.sv
// dcache_responder
//   Responder for the memory-access stage's data-memory requests. Implements a
//   direct-mapped, write-through, read-allocate, no-write-allocate data cache
//   with one-word lines. Load hits answer one cycle after accept; load misses
//   and all stores go to backing memory over a req/ack handshake, followed by a
//   one-cycle response pulse.
//
//   Optional build macro DCACHE_STATS_EN adds registered hit_count/miss_count
//   outputs counting accepted load hits and load misses (stores not counted).
module dcache_responder #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int NUM_LINES = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
`endif
);

   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = ADDR_W - 2 - IDX_W;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_REFILL = 2'd1,
      S_WRITE  = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_next;

   // Line storage: valid bits are reset, tag/data arrays are not.
   logic [NUM_LINES-1:0] r_valid;
   logic [TAG_W-1:0]     r_tag_mem  [NUM_LINES];
   logic [DATA_W-1:0]    r_data_mem [NUM_LINES];

   // Registered outputs; r_mem_addr also holds the latched request address
   // while a backing-memory transfer is outstanding.
   logic              r_resp_valid;
   logic [DATA_W-1:0] r_resp_rdata;
   logic              r_mem_req;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;

   logic [IDX_W-1:0]  w_req_idx;
   logic [TAG_W-1:0]  w_req_tag;
   logic [ADDR_W-1:0] w_req_waddr;
   logic [IDX_W-1:0]  w_pend_idx;
   logic [TAG_W-1:0]  w_pend_tag;
   logic              w_hit;
   logic              w_arr_we;
   logic              w_tag_we;
   logic [IDX_W-1:0]  w_arr_idx;
   logic [DATA_W-1:0] w_arr_data;
   logic              w_unused_addr_lsb;

   assign w_req_idx   = req_addr[2+IDX_W-1:2];
   assign w_req_tag   = req_addr[ADDR_W-1:2+IDX_W];
   assign w_req_waddr = {req_addr[ADDR_W-1:2], 2'b00};
   assign w_pend_idx  = r_mem_addr[2+IDX_W-1:2];
   assign w_pend_tag  = r_mem_addr[ADDR_W-1:2+IDX_W];
   assign w_hit       = r_valid[w_req_idx] && (r_tag_mem[w_req_idx] == w_req_tag);

   // Byte-offset bits carry no meaning for word accesses.
   assign w_unused_addr_lsb = ^req_addr[1:0];

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values, independent of block evaluation order.
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // Next-state and array write-port selection.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a value
      // unassigned, which would otherwise infer a latch.
      w_state_next = r_state;
      w_arr_we     = 1'b0;
      w_tag_we     = 1'b0;
      w_arr_idx    = w_req_idx;
      w_arr_data   = req_wdata;
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               if (req_we) begin
                  // Store hits update the cached word; misses do not allocate.
                  w_state_next = S_WRITE;
                  w_arr_we     = w_hit && reset;
               end else if (!w_hit) begin
                  w_state_next = S_REFILL;
               end
            end
         end
         S_REFILL: begin
            if (mem_ack) begin
               w_state_next = S_RESP;
               w_arr_we     = reset;
               w_tag_we     = 1'b1;
               w_arr_idx    = w_pend_idx;
               w_arr_data   = mem_rdata;
            end
         end
         S_WRITE: begin
            if (mem_ack) w_state_next = S_RESP;
         end
         S_RESP: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Tag and data arrays: single write port shared by store hits and refills.
   always_ff @(posedge clk) begin
      // NOTE: storage arrays carry no reset; the valid bits alone decide
      // whether a line's contents are meaningful.
      if (w_arr_we) begin
         r_data_mem[w_arr_idx] <= w_arr_data;
         if (w_tag_we) r_tag_mem[w_arr_idx] <= w_pend_tag;
      end
   end

   // Valid bits, response pulse and backing-memory request registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid      <= '0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= '0;
         r_mem_req    <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
      end else begin
         r_resp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  if (req_we) begin
                     r_mem_req   <= 1'b1;
                     r_mem_we    <= 1'b1;
                     r_mem_addr  <= w_req_waddr;
                     r_mem_wdata <= req_wdata;
                  end else if (w_hit) begin
                     r_resp_valid <= 1'b1;
                     r_resp_rdata <= r_data_mem[w_req_idx];
                  end else begin
                     r_mem_req  <= 1'b1;
                     r_mem_we   <= 1'b0;
                     r_mem_addr <= w_req_waddr;
                  end
               end
            end
            S_REFILL: begin
               if (mem_ack) begin
                  r_valid[w_pend_idx] <= 1'b1;
                  r_mem_req           <= 1'b0;
                  r_resp_valid        <= 1'b1;
                  r_resp_rdata        <= mem_rdata;
               end
            end
            S_WRITE: begin
               if (mem_ack) begin
                  r_mem_req    <= 1'b0;
                  r_mem_we     <= 1'b0;
                  r_resp_valid <= 1'b1;
                  r_resp_rdata <= '0;
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] r_hit_count;
   logic [31:0] r_miss_count;

   // Load hit/miss counters, advanced once per accepted load.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hit_count  <= '0;
         r_miss_count <= '0;
      end else if ((r_state == S_IDLE) && req_valid && !req_we) begin
         if (w_hit) r_hit_count  <= r_hit_count + 32'd1;
         else       r_miss_count <= r_miss_count + 32'd1;
      end
   end

   assign hit_count  = r_hit_count;
   assign miss_count = r_miss_count;
`endif

   assign req_ready  = (r_state == S_IDLE);
   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign mem_req    = r_mem_req;
   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_dcache_responder.sv
// Testbench for dcache_responder. The reference model treats the cache as a
// set of cached word addresses (at most one per line index) in front of a
// write-through backing memory; cached data therefore always equals backing
// memory. One compare process checks the DUT against per-cycle expectations.
module tb_dcache_responder;

   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 32;
   localparam int NUM_LINES = 16;

   logic              clk;
   logic              reset;
   logic              req_valid;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              req_ready;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_rdata;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;
`ifdef DCACHE_STATS_EN
   logic [31:0]       hit_count;
   logic [31:0]       miss_count;
`endif

   dcache_responder #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_LINES(NUM_LINES)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef DCACHE_STATS_EN
      , .hit_count(hit_count), .miss_count(miss_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Per-cycle expectations, written by the stimulus, read by the compare process.
   bit          chk_en = 1'b0;
   bit          exp_ready, exp_resp_valid, exp_mem_req, exp_mem_we;
   logic [31:0] exp_resp_rdata, exp_mem_addr, exp_mem_wdata;

   // Reference model state.
   logic [31:0] bmem   [logic [31:0]];
   bit          cached [logic [31:0]];
   int          m_hits, m_misses;

   int          last_req_cycles;
   logic [31:0] last_rdata;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h @%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] bmem_rd(input logic [31:0] a);
      if (bmem.exists(a)) return bmem[a];
      return a ^ 32'hA5A5_0000;
   endfunction

   function automatic int line_of(input logic [31:0] a);
      return int'((a >> 2) % NUM_LINES);
   endfunction

   // Read-allocate: the new word displaces whatever shared its line.
   task automatic model_allocate(input logic [31:0] wa);
      logic [31:0] victims[$];
      foreach (cached[k]) if (line_of(k) == line_of(wa)) victims.push_back(k);
      foreach (victims[i]) cached.delete(victims[i]);
      cached[wa] = 1'b1;
   endtask

   task automatic model_reset();
      cached.delete();
      m_hits   = 0;
      m_misses = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      exp_resp_valid = 1'b0;
   endtask

   // One request; ends in the first cycle where a new request may be driven.
   task automatic do_op(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int ack_delay);
      logic [31:0] wa;
      bit          hit;
      wa  = {addr[31:2], 2'b00};
      hit = !we && cached.exists(wa);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
      exp_ready = 1'b1; exp_mem_req = 1'b0;
      step();
      req_valid = 1'b0; req_we = 1'b0; req_addr = $urandom; req_wdata = $urandom;
      if (!we) begin
         if (hit) m_hits++;
         else     m_misses++;
      end
      last_req_cycles = 0;
      if (hit) begin
         exp_resp_valid = 1'b1;
         exp_resp_rdata = bmem_rd(wa);
         last_rdata     = resp_rdata;
         return;
      end
      exp_ready = 1'b0; exp_mem_req = 1'b1; exp_mem_we = we;
      exp_mem_addr = wa; exp_mem_wdata = wdata;
      for (int c = 1; c <= ack_delay; c++) begin
         if (mem_req) last_req_cycles++;
         if (c == ack_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = we ? $urandom : bmem_rd(wa);
         end else begin
            step();
         end
      end
      step();
      mem_ack = 1'b0; mem_rdata = $urandom;
      if (we) bmem[wa] = wdata;
      else    model_allocate(wa);
      exp_mem_req = 1'b0; exp_mem_we = 1'b0;
      exp_resp_valid = 1'b1;
      exp_resp_rdata = we ? 32'h0 : bmem_rd(wa);
      last_rdata = resp_rdata;
      step();
      exp_ready = 1'b1;
   endtask

   // Compare process: DUT outputs against expectations on every falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("req_ready", req_ready, exp_ready);
         check("resp_valid", resp_valid, exp_resp_valid);
         if (exp_resp_valid) check("resp_rdata", resp_rdata, exp_resp_rdata);
         check("mem_req", mem_req, exp_mem_req);
         if (exp_mem_req) begin
            check("mem_we", mem_we, exp_mem_we);
            check("mem_addr", mem_addr, exp_mem_addr);
            if (exp_mem_we) check("mem_wdata", mem_wdata, exp_mem_wdata);
         end
`ifdef DCACHE_STATS_EN
         check("hit_count", hit_count, m_hits);
         check("miss_count", miss_count, m_misses);
`endif
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      exp_ready = 1'b1; exp_resp_valid = 1'b0; exp_mem_req = 1'b0; exp_mem_we = 1'b0;
      exp_resp_rdata = '0; exp_mem_addr = '0; exp_mem_wdata = '0;
      model_reset();
      bmem[32'h100] = 32'hDEAD_BEEF;
      #1 reset = 1'b0;
      chk_en = 1'b1;
      step(); step();
      check("rst_resp_rdata", resp_rdata, 32'h0);
      check("rst_mem_we", mem_we, 1'b0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      reset = 1'b1;
      step();

      // Cold miss with three-cycle memory latency, then hits.
      do_op(1'b0, 32'h100, 32'h0, 3);
      check("first_load_data", last_rdata, 32'hDEAD_BEEF);
      check("first_load_req_cycles", last_req_cycles, 3);
      mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;   // ack while idle must be ignored
      step();
      mem_ack = 1'b0;
      do_op(1'b0, 32'h100, 32'h0, 1);
      check("repeat_hit_data", last_rdata, 32'hDEAD_BEEF);
      do_op(1'b0, 32'h100, 32'h0, 1);              // back-to-back hit

      // Store hit with ack in the first request cycle, then load of new data.
      do_op(1'b1, 32'h100, 32'h1234_5678, 1);
      check("store_resp_rdata", last_rdata, 32'h0);
      do_op(1'b0, 32'h100, 32'h0, 1);
      check("load_after_store", last_rdata, 32'h1234_5678);

      // Store miss to same index, different tag: no allocation.
      do_op(1'b1, 32'h140, 32'hCAFE_F00D, 2);
      check("pin_no_write_alloc", cached.exists(32'h140), 1'b0);
      do_op(1'b0, 32'h100, 32'h0, 1);
      check("conflict_store_keeps_line", last_rdata, 32'h1234_5678);
      do_op(1'b0, 32'h140, 32'h0, 1);
      check("load_140_miss_cycles", last_req_cycles, 1);
      check("load_140_data", last_rdata, 32'hCAFE_F00D);
      do_op(1'b0, 32'h100, 32'h0, 2);
      check("evicted_100_miss_cycles", last_req_cycles, 2);
      check("evicted_100_write_through", last_rdata, 32'h1234_5678);

      // Another line; byte-offset bits ignored on the follow-up hit.
      do_op(1'b0, 32'h104, 32'h0, 1);
      do_op(1'b0, 32'h107, 32'h0, 1);
      check("offset_ignored_hit", last_rdata, 32'hA5A5_0104);
      check("pin_model_hits", m_hits, 5);
      check("pin_model_misses", m_misses, 4);

      // Reset in the middle of a refill.
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h200;
      exp_ready = 1'b1;
      step();
      req_valid = 1'b0;
      m_misses++;
      exp_ready = 1'b0; exp_mem_req = 1'b1; exp_mem_we = 1'b0; exp_mem_addr = 32'h200;
      step(); step();
      reset = 1'b0;
      #1;
      check("rst_drops_mem_req", mem_req, 1'b0);
      check("rst_ready_async", req_ready, 1'b1);
      model_reset();
      exp_mem_req = 1'b0; exp_ready = 1'b1;
      step(); step();
      reset = 1'b1;
      step();
      check("rst2_mem_addr", mem_addr, 32'h0);
      check("rst2_resp_rdata", resp_rdata, 32'h0);
      step(); step();

      // After reset: 2 misses, 3 hits, 1 store.
      do_op(1'b0, 32'h200, 32'h0, 1);
      check("reload_200_misses", last_req_cycles, 1);
      check("reload_200_data", last_rdata, 32'hA5A5_0200);
      do_op(1'b0, 32'h200, 32'h0, 1);
      do_op(1'b1, 32'h200, 32'h55AA_55AA, 1);
      do_op(1'b0, 32'h204, 32'h0, 2);
      do_op(1'b0, 32'h204, 32'h0, 1);
      do_op(1'b0, 32'h200, 32'h0, 1);
      check("final_hit_data", last_rdata, 32'h55AA_55AA);
      check("pin_model_hits_2", m_hits, 3);
      check("pin_model_misses_2", m_misses, 2);
`ifdef DCACHE_STATS_EN
      check("stats_hit_count", hit_count, 32'd3);
      check("stats_miss_count", miss_count, 32'd2);
`endif
      step();
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
